// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, opcode defaults, special addresses and bus struct for mem_arb
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [7:0] RD_OP_DEF  = 8'b0100_0000;
    localparam logic [7:0] WR_OP_DEF  = 8'b1000_0000;
    localparam logic [7:0] NOP_OP_DEF = 8'h00;
    localparam logic [4:0] IN_ADDR    = 5'd30;
    localparam logic [4:0] OUT_ADDR   = 5'd31;
    typedef struct packed {
        logic [4:0] a_bus;
        logic [7:0] instruction;
        logic       dbus_sel;
        logic [7:0] d_out;
        logic       d_oe;
    } bus_t;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: two requester handshakes plus the memory bus
// slave = arbiter side (drives gnt/ack/err/rdata and the memory bus), master = requesters and memory
interface mem_arb_if;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, ack0, ack1, err0, err1;
    logic [7:0] rdata;
    logic [4:0] a_bus;
    logic [7:0] instruction;
    logic       dbus_sel;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] d_in;
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, d_in,
        output gnt0, gnt1, ack0, ack1, err0, err1, rdata,
               a_bus, instruction, dbus_sel, d_out, d_oe
    );
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, d_in,
        input  gnt0, gnt1, ack0, ack1, err0, err1, rdata,
               a_bus, instruction, dbus_sel, d_out, d_oe
    );
endinterface

// File: rtl/mem_arb_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker
// ports: req (request vector), last (index served last), win (winner index)
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);
    assign win = &req ? ~last : req[1];
endmodule

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter giving two requesters 3-cycle access to a single memory bus
// ports: clk, rst (async, active-high), m (mem_arb_if.slave: requester handshakes + memory bus)
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter logic [7:0] RD_OP  = RD_OP_DEF,
    parameter logic [7:0] WR_OP  = WR_OP_DEF,
    parameter logic [7:0] NOP_OP = NOP_OP_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  m
);
    localparam bus_t BUS_IDLE = '{5'd0, NOP_OP, 1'b1, 8'd0, 1'b0};

    state_t     state_q, state_d;
    logic       last_q, last_d, win_q, win_d, we_q, we_d, win;
    logic [4:0] addr_q, addr_d;
    logic [1:0] gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    bus_t       bus_q, bus_d;

    // Writes to the input port are suppressed: no strobe, bus left undriven.
    function automatic bus_t access_bus(input logic we, input logic [4:0] addr, input logic [7:0] wdata);
        bus_t b;
        b.a_bus       = addr;
        b.instruction = !we ? RD_OP : (addr == IN_ADDR ? NOP_OP : WR_OP);
        b.dbus_sel    = we;
        b.d_oe        = we && addr != IN_ADDR;
        b.d_out       = b.d_oe ? wdata : 8'h00;
        return b;
    endfunction

    rr_pick2 u_pick (.req({m.req1, m.req0}), .last(last_q), .win(win));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        gnt_d   = gnt_q;
        ack_d   = 2'b00;
        err_d   = 2'b00;
        rdata_d = rdata_q;
        bus_d   = BUS_IDLE;
        case (state_q)
            IDLE: if (m.req0 || m.req1) begin
                state_d = ACCESS;
                win_d   = win;
                last_d  = win;
                we_d    = win ? m.we1 : m.we0;
                addr_d  = win ? m.addr1 : m.addr0;
                gnt_d   = win ? 2'b10 : 2'b01;
                bus_d   = access_bus(we_d, addr_d, win ? m.wdata1 : m.wdata0);
            end
            ACCESS: begin
                state_d = DONE;
                ack_d   = win_q ? 2'b10 : 2'b01;
                err_d   = {2{we_q && addr_q == IN_ADDR}} & ack_d;
                rdata_d = we_q ? rdata_q : m.d_in;
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 5'd0;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            err_q   <= 2'b00;
            rdata_q <= 8'h00;
            bus_q   <= BUS_IDLE;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            bus_q   <= bus_d;
        end
    end

    assign {m.gnt1, m.gnt0} = gnt_q;
    assign {m.ack1, m.ack0} = ack_q;
    assign {m.err1, m.err0} = err_q;
    assign m.rdata          = rdata_q;
    assign m.a_bus          = bus_q.a_bus;
    assign m.instruction    = bus_q.instruction;
    assign m.dbus_sel       = bus_q.dbus_sel;
    assign m.d_out          = bus_q.d_out;
    assign m.d_oe           = bus_q.d_oe;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb
module tb_mem_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arb_if bus();
    mem_arb dut (.clk(clk), .rst(rst), .m(bus));

    typedef struct {
        int         id;
        logic       err;
        logic       rd;
        logic [7:0] rdata;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_excl", {31'd0, bus.gnt0 & bus.gnt1}, 0);
            if (bus.ack0 || bus.ack1) begin
                check("ack_excl", {31'd0, bus.ack0 & bus.ack1}, 0);
                if (sb.size() == 0) check("ack_unexpected", {31'd0, bus.ack0 | bus.ack1}, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_id", {31'd0, bus.ack1}, e.id);
                    check("ack_err", {31'd0, bus.ack1 ? bus.err1 : bus.err0}, {31'd0, e.err});
                    if (e.rd) check("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
                end
            end
        end
    end

    task automatic run_txn(input bit id, input logic we, input logic [4:0] addr, input logic [7:0] wd,
                           input logic [7:0] din, input logic [7:0] exp_instr, input logic exp_sel,
                           input logic exp_oe, input logic [7:0] exp_dout, input logic exp_err);
        sb.push_back('{int'(id), exp_err, !we, din});
        if (id) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end
        bus.d_in = din;
        @(negedge clk);
        check("acc_gnt", {30'd0, bus.gnt1, bus.gnt0}, id ? 2 : 1);
        check("acc_a_bus", {27'd0, bus.a_bus}, {27'd0, addr});
        check("acc_instr", {24'd0, bus.instruction}, {24'd0, exp_instr});
        check("acc_sel", {31'd0, bus.dbus_sel}, {31'd0, exp_sel});
        check("acc_oe", {31'd0, bus.d_oe}, {31'd0, exp_oe});
        check("acc_dout", {24'd0, bus.d_out}, {24'd0, exp_dout});
        check("acc_no_ack", {30'd0, bus.ack1, bus.ack0}, 0);
        @(negedge clk);
        check("done_ack", {30'd0, bus.ack1, bus.ack0}, id ? 2 : 1);
        check("done_gnt", {30'd0, bus.gnt1, bus.gnt0}, id ? 2 : 1);
        check("done_idle_bus", {bus.a_bus, bus.instruction, bus.dbus_sel, bus.d_oe}, {5'd0, 8'h00, 1'b1, 1'b0});
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        check("gnt_drop", {30'd0, bus.gnt1, bus.gnt0}, 0);
    endtask

    initial begin
        int n;
        int last_t;
        rst = 1'b1;
        {bus.req0, bus.req1, bus.we0, bus.we1} = '0;
        {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1, bus.d_in} = '0;
        @(negedge clk);
        check("rst_gnt_ack_err", {26'd0, bus.gnt1, bus.gnt0, bus.ack1, bus.ack0, bus.err1, bus.err0}, 0);
        check("rst_bus", {bus.a_bus, bus.instruction, bus.dbus_sel, bus.d_out, bus.d_oe}, {5'd0, 8'h00, 1'b1, 8'h00, 1'b0});
        check("rst_rdata", {24'd0, bus.rdata}, 0);
        rst = 1'b0;

        run_txn(1'b0, 1'b0, 5'd3, 8'h00, 8'hA5, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0);
        run_txn(1'b1, 1'b1, 5'd31, 8'h55, 8'h00, 8'h80, 1'b1, 1'b1, 8'h55, 1'b0);
        run_txn(1'b0, 1'b1, 5'd30, 8'h77, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        run_txn(1'b0, 1'b0, 5'd12, 8'h00, 8'h5A, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0);
        run_txn(1'b0, 1'b0, 5'd13, 8'h00, 8'h96, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rdata_held", {24'd0, bus.rdata}, 32'h96);

        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd7; bus.d_in = 8'hC3;
        @(negedge clk);
        check("abort_gnt", {31'd0, bus.gnt0}, 1);
        rst = 1'b1;
        #1;
        check("abort_gnt_clr", {30'd0, bus.gnt1, bus.gnt0}, 0);
        check("abort_bus", {bus.a_bus, bus.instruction, bus.dbus_sel, bus.d_oe}, {5'd0, 8'h00, 1'b1, 1'b0});
        bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_ack", {30'd0, bus.ack1, bus.ack0}, 0);
        end
        run_txn(1'b0, 1'b0, 5'd7, 8'h00, 8'hC3, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) sb.push_back('{(k % 2 == 0) ? 1 : 0, 1'b0, 1'b1, 8'h3C});
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd5;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd6;
        bus.d_in = 8'h3C;
        n = 0;
        last_t = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                if (n > 0) check("ack_gap", c - last_t, 3);
                last_t = c;
                n++;
                if (n == 4) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
        end
        check("tie_ack_count", n, 4);
        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
